// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.
// Fetch lookups respond one cycle later; execute writebacks update or allocate entries.
module branch_target_buffer #(
  parameter int         INDEX_BITS  = 4,
  parameter int         ADDR_W      = 32,
  parameter logic [1:0] ALLOC_STATE = 2'b10
) (
  input  logic              btb_clk,
  input  logic              btb_rst_n,
  input  logic              btb_lookup_valid,
  input  logic [ADDR_W-1:0] btb_lookup_pc,
  output logic              btb_resp_valid,
  output logic              btb_resp_hit,
  output logic              btb_resp_taken,
  output logic [ADDR_W-1:0] btb_resp_next_pc,
  output logic [1:0]        btb_resp_prediction,
  input  logic              btb_update_valid,
  input  logic [ADDR_W-1:0] btb_update_pc,
  input  logic [ADDR_W-1:0] btb_update_target,
  input  logic              btb_update_taken
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_W - INDEX_BITS - 2;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [1:0]        ctr;
  } entry_t;

  entry_t table_q [ENTRIES];

  logic              resp_valid_q, resp_hit_q, resp_taken_q;
  logic [ADDR_W-1:0] resp_next_pc_q;
  logic [1:0]        resp_pred_q;

  // PC byte-offset bits never participate in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{btb_lookup_pc[1:0], btb_update_pc[1:0]};

  // Lookup path: reads the table as it stands before this edge's update.
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  entry_t                lk_entry;
  logic                  lk_hit, lk_taken;
  logic [ADDR_W-1:0]     lk_next_pc;
  logic [1:0]            lk_pred;

  always_comb begin
    lk_idx     = btb_lookup_pc[INDEX_BITS+1:2];
    lk_tag     = btb_lookup_pc[ADDR_W-1:INDEX_BITS+2];
    lk_entry   = table_q[lk_idx];
    lk_hit     = lk_entry.valid && (lk_entry.tag == lk_tag);
    lk_taken   = lk_hit && lk_entry.ctr[1];
    lk_next_pc = lk_taken ? lk_entry.target : btb_lookup_pc + ADDR_W'(4);
    lk_pred    = lk_hit ? lk_entry.ctr : 2'b00;
  end

  // Update path: build the replacement entry for the written index.
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      up_tag;
  entry_t                up_entry;
  logic                  up_hit;
  entry_t                entry_d;
  logic                  entry_we;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    up_idx   = btb_update_pc[INDEX_BITS+1:2];
    up_tag   = btb_update_pc[ADDR_W-1:INDEX_BITS+2];
    up_entry = table_q[up_idx];
    up_hit   = up_entry.valid && (up_entry.tag == up_tag);
    entry_d  = up_entry;
    entry_we = 1'b0;
    if (btb_update_valid) begin
      if (up_hit) begin
        entry_we = 1'b1;
        if (btb_update_taken) begin
          entry_d.target = btb_update_target;
          if (up_entry.ctr != 2'b11) entry_d.ctr = up_entry.ctr + 2'd1;
        end else if (up_entry.ctr != 2'b00) begin
          entry_d.ctr = up_entry.ctr - 2'd1;
        end
      end else if (btb_update_taken) begin
        entry_we       = 1'b1;
        entry_d.valid  = 1'b1;
        entry_d.tag    = up_tag;
        entry_d.target = btb_update_target;
        entry_d.ctr    = ALLOC_STATE;
      end
    end
  end

  // NOTE: the table is small and built from flops, so it is reset explicitly;
  // a RAM-based table would instead clear only the valid bits.
  always_ff @(posedge btb_clk or negedge btb_rst_n) begin
    if (!btb_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
    end else if (entry_we) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      table_q[up_idx] <= entry_d;
    end
  end

  // Response fields hold their last value when no lookup is issued.
  always_ff @(posedge btb_clk or negedge btb_rst_n) begin
    if (!btb_rst_n) begin
      resp_valid_q   <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_taken_q   <= 1'b0;
      resp_next_pc_q <= '0;
      resp_pred_q    <= 2'b00;
    end else begin
      resp_valid_q <= btb_lookup_valid;
      if (btb_lookup_valid) begin
        resp_hit_q     <= lk_hit;
        resp_taken_q   <= lk_taken;
        resp_next_pc_q <= lk_next_pc;
        resp_pred_q    <= lk_pred;
      end
    end
  end

  assign btb_resp_valid      = resp_valid_q;
  assign btb_resp_hit        = resp_hit_q;
  assign btb_resp_taken      = resp_taken_q;
  assign btb_resp_next_pc    = resp_next_pc_q;
  assign btb_resp_prediction = resp_pred_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed vectors, a behavioural table model
// compared every cycle, and hand-computed literal checks.
module tb_branch_target_buffer;

  logic        clk, rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        resp_valid, resp_hit, resp_taken;
  logic [31:0] resp_next_pc;
  logic [1:0]  resp_pred;
  logic        update_valid, update_taken;
  logic [31:0] update_pc, update_target;

  branch_target_buffer dut (
    .btb_clk            (clk),
    .btb_rst_n          (rst_n),
    .btb_lookup_valid   (lookup_valid),
    .btb_lookup_pc      (lookup_pc),
    .btb_resp_valid     (resp_valid),
    .btb_resp_hit       (resp_hit),
    .btb_resp_taken     (resp_taken),
    .btb_resp_next_pc   (resp_next_pc),
    .btb_resp_prediction(resp_pred),
    .btb_update_valid   (update_valid),
    .btb_update_pc      (update_pc),
    .btb_update_target  (update_target),
    .btb_update_taken   (update_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model: 16 slots addressed by word number mod 16, tag = pc / 64.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_ctr   [16];
  bit          e_valid, e_hit, e_taken;
  int unsigned e_npc;
  int          e_pred;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      e_valid = 0; e_hit = 0; e_taken = 0; e_npc = 0; e_pred = 0;
    end else begin
      if (lookup_valid) begin
        int unsigned idx;
        idx     = (lookup_pc / 4) % 16;
        e_hit   = m_valid[idx] && (m_tag[idx] == lookup_pc / 64);
        e_pred  = e_hit ? m_ctr[idx] : 0;
        e_taken = e_hit && (m_ctr[idx] >= 2);
        e_npc   = e_taken ? m_tgt[idx] : lookup_pc + 4;
      end
      e_valid = lookup_valid;
      if (update_valid) begin
        int unsigned idx;
        bit hit;
        idx = (update_pc / 4) % 16;
        hit = m_valid[idx] && (m_tag[idx] == update_pc / 64);
        if (hit && update_taken) begin
          m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
          m_tgt[idx] = update_target;
        end else if (hit) begin
          m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end else if (update_taken) begin
          m_valid[idx] = 1; m_tag[idx] = update_pc / 64;
          m_tgt[idx] = update_target; m_ctr[idx] = 2;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_valid", {31'd0, resp_valid}, {31'd0, e_valid});
      check("model_hit",   {31'd0, resp_hit},   {31'd0, e_hit});
      check("model_taken", {31'd0, resp_taken}, {31'd0, e_taken});
      check("model_npc",   resp_next_pc,        e_npc);
      check("model_pred",  {30'd0, resp_pred},  e_pred);
    end
  end

  // Drive one cycle of inputs at a falling edge; return at the next falling edge.
  task automatic step(input bit lv, input logic [31:0] lpc, input bit uv,
                      input logic [31:0] upc, input logic [31:0] utgt, input bit utk);
    lookup_valid = lv; lookup_pc = lpc;
    update_valid = uv; update_pc = upc; update_target = utgt; update_taken = utk;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lk(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, 0);
  endtask

  task automatic up(input logic [31:0] pc, input logic [31:0] tgt, input bit tk);
    step(0, 0, 1, pc, tgt, tk);
  endtask

  task automatic expect_resp(input string tag, input bit v, input bit h, input bit t,
                             input logic [31:0] npc, input logic [1:0] p);
    check({tag, "_valid"}, {31'd0, resp_valid}, {31'd0, v});
    check({tag, "_hit"},   {31'd0, resp_hit},   {31'd0, h});
    check({tag, "_taken"}, {31'd0, resp_taken}, {31'd0, t});
    check({tag, "_npc"},   resp_next_pc,        npc);
    check({tag, "_pred"},  {30'd0, resp_pred},  {30'd0, p});
  endtask

  initial begin
    rst_n = 1'b0;
    lookup_valid = 0; lookup_pc = 0;
    update_valid = 0; update_pc = 0; update_target = 0; update_taken = 0;
    @(negedge clk);
    expect_resp("reset", 0, 0, 0, 32'h0, 2'b00);
    rst_n = 1'b1;

    lk(32'h100);                  expect_resp("cold",   1, 0, 0, 32'h104, 2'b00);
    up(32'h100, 32'h200, 1);
    lk(32'h100);                  expect_resp("alloc",  1, 1, 1, 32'h200, 2'b10);
    for (int i = 0; i < 3; i++) up(32'h100, 32'h200, 1);
    lk(32'h100);                  expect_resp("sat_hi", 1, 1, 1, 32'h200, 2'b11);
    up(32'h100, 0, 0); lk(32'h100); check("dec1", {30'd0, resp_pred}, 32'd2);
    up(32'h100, 0, 0); lk(32'h100); check("dec2", {30'd0, resp_pred}, 32'd1);
    up(32'h100, 0, 0); lk(32'h100); expect_resp("dec3",  1, 1, 0, 32'h104, 2'b00);
    up(32'h100, 0, 0); lk(32'h100); expect_resp("sat_lo", 1, 1, 0, 32'h104, 2'b00);

    // Aliasing: 0x500 shares index 0 with 0x100 and evicts it.
    up(32'h100, 32'h200, 1);
    up(32'h500, 32'h600, 1);
    lk(32'h100);                  expect_resp("evicted", 1, 0, 0, 32'h104, 2'b00);
    lk(32'h500);                  expect_resp("alias",   1, 1, 1, 32'h600, 2'b10);

    // Same-cycle lookup and update: lookup sees pre-update state.
    up(32'h100, 32'h200, 1);
    step(1, 32'h100, 1, 32'h100, 32'h0, 0);
    expect_resp("hazard", 1, 1, 1, 32'h200, 2'b10);
    lk(32'h100);                  expect_resp("post_hz", 1, 1, 0, 32'h104, 2'b01);

    step(0, 32'h0, 0, 0, 0, 0);   expect_resp("hold",    0, 1, 0, 32'h104, 2'b01);
    lk(32'h102);                  expect_resp("offset",  1, 1, 0, 32'h106, 2'b01);
    lk(32'hFFFF_FFFC);            expect_resp("wrap",    1, 0, 0, 32'h0,   2'b00);

    up(32'h344, 32'h1000, 1);
    lk(32'h344);                  expect_resp("idx1",    1, 1, 1, 32'h1000, 2'b10);

    // Asynchronous reset between edges clears outputs immediately.
    #2 rst_n = 1'b0;
    #1 expect_resp("async_rst", 0, 0, 0, 32'h0, 2'b00);
    #1 rst_n = 1'b1;
    @(negedge clk);
    up(32'h300, 32'h900, 0);
    lk(32'h300);                  expect_resp("nt_miss", 1, 0, 0, 32'h304, 2'b00);
    lk(32'h344);                  expect_resp("rst_344", 1, 0, 0, 32'h348, 2'b00);
    lk(32'h500);                  expect_resp("rst_500", 1, 0, 0, 32'h504, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Direct-mapped branch target buffer; the table that holds and serves the 2-bit saturating prediction state.
- Fetch stage issues a PC lookup and receives hit, predicted direction and predicted next PC one cycle later.
- Execute stage writes back resolved branches, which updates counters and allocates entries.
- This block reads and writes the same 2-bit prediction encoding used by branch_target_buffer_FSM: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Parameters:
- INDEX_BITS, 4, log2 of entry count (16 entries).
- ADDR_W, 32, PC and target width.
- ALLOC_STATE, 2'b10, counter value written on a newly allocated entry.

Ports:
- btb_clk  input  1  clock; all state updates on rising edge.
- btb_rst_n  input  1  reset, asynchronous assert, active-low.
- btb_lookup_valid  input  1  fetch lookup request this cycle.
- btb_lookup_pc  input  ADDR_W  fetch PC.
- btb_resp_valid  output  1  response valid (lookup_valid delayed 1 cycle).
- btb_resp_hit  output  1  tag match on a valid entry.
- btb_resp_taken  output  1  hit && counter[1].
- btb_resp_next_pc  output  ADDR_W  stored target if btb_resp_taken, else lookup PC + 4.
- btb_resp_prediction  output  2  counter value of the hit entry; 2'b00 on miss.
- btb_update_valid  input  1  resolved branch writeback.
- btb_update_pc  input  ADDR_W  PC of the resolved branch.
- btb_update_target  input  ADDR_W  resolved taken target.
- btb_update_taken  input  1  actual outcome.

Behaviour:
- Index = pc[INDEX_BITS+1:2]; tag = pc[ADDR_W-1:INDEX_BITS+2]; pc[1:0] ignored.
- Storage per entry: valid bit, tag, target, 2-bit counter.
- Reset (async, btb_rst_n=0): all valid bits cleared; all counters set to 2'b01; targets and tags set to 0. Response registers btb_resp_valid, btb_resp_hit, btb_resp_taken, btb_resp_next_pc and btb_resp_prediction all go to 0.
- Reset asserted mid-operation discards any pending response. The first lookup after release sees an empty table.
- Lookup latency is exactly 1 cycle:
  - lookup_valid sampled at edge N produces resp_valid=1 for the cycle after edge N, with fields computed from table state before edge N's update.
  - With lookup_valid=0, resp_valid=0 and the other response fields hold their previous values.
- Update when update_valid=1, at the rising edge:
  - Hit (valid && tag match), taken: counter saturating +1 (11 stays 11). Target overwritten with update_target.
  - Hit, not taken: counter saturating -1 (00 stays 00). Target unchanged.
  - Miss, taken: allocate. Set valid=1, tag, target, and counter=ALLOC_STATE; any prior occupant of the index is evicted.
  - Miss, not taken: no table change.
- Simultaneous lookup and update on the same index in the same cycle: the lookup is read-before-write and returns the pre-update state. There is no bypass.
- Updates never stall, and there is no backpressure. One update and one lookup can occur per cycle.
- next_pc arithmetic is ADDR_W-bit modulo, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.

Test Plan:
- Reset, then lookup PC 0x100 -> next cycle resp_valid=1, hit=0, taken=0, next_pc=0x104, prediction=00.
- Update PC 0x100 taken, target 0x200; then lookup 0x100 -> hit=1, prediction=10, taken=1, next_pc=0x200.
- Three more taken updates on 0x100 -> prediction 11 (saturates). Then three not-taken updates -> 10, 01, 00; lookup gives taken=0, next_pc=0x104.
- Aliasing:
  - Allocate 0x100 taken (target 0x200), then update 0x500 taken (same index 0, different tag) with target 0x600.
  - Lookup 0x100 -> hit=0. Lookup 0x500 -> hit=1, next_pc=0x600.
- Same-cycle hazard: entry 0x100 at 10; in one cycle lookup 0x100 and update 0x100 not-taken. Response shows prediction=10, taken=1; the following lookup shows 01, taken=0.
- Mid-operation reset: allocate entries, pulse btb_rst_n low asynchronously between edges. All outputs go to 0 immediately, and subsequent lookups miss. Also check a not-taken miss update on 0x300, followed by a lookup, returns hit=0.
